fb_access_arbiter: RTL

Two-requester command arbiter that shares the single DDR4 frame-buffer command port between the HDMI display reader (read bursts) and the DDR loader (write bursts). Sits between the requesters and the AXI master shims that feed the interconnect. Display reads have priority because they are real-time. An optional streak counter keeps the loader from starving. Exactly one burst is outstanding at any time.

---
 rtl/fb_access_arbiter_pkg.sv | 15 +
 rtl/fb_access_arbiter_if.sv | 22 ++
 rtl/fb_access_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fb_access_arbiter_pkg.sv
// Shared types for the frame-buffer command arbiter: FSM states and burst owner.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_RD = 1'b0,
    OWN_WR = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/fb_access_arbiter_if.sv
// Downstream command bus between the arbiter (master) and the AXI master shims (slave).
interface fb_access_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
);
  logic              cmd_valid_o;
  logic              cmd_ready_i;
  logic              cmd_we_o;
  logic [ADDR_W-1:0] cmd_addr_o;
  logic [LEN_W-1:0]  cmd_len_o;
  logic              xfer_done_i;

  modport master (
    output cmd_valid_o, cmd_we_o, cmd_addr_o, cmd_len_o,
    input  cmd_ready_i, xfer_done_i
  );

  modport slave (
    input  cmd_valid_o, cmd_we_o, cmd_addr_o, cmd_len_o,
    output cmd_ready_i, xfer_done_i
  );
endinterface

// File: rtl/fb_access_arbiter.sv
// Shares one DDR4 frame-buffer command port between display reads and loader writes.
// Optional anti-starvation streak counter enabled by defining FB_ARB_STARVE_EN.
module fb_access_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int LEN_W         = 8,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,

  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [LEN_W-1:0]  rd_len_i,
  output logic              rd_gnt_o,
  output logic              rd_done_o,

  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [LEN_W-1:0]  wr_len_i,
  output logic              wr_gnt_o,
  output logic              wr_done_o,

  fb_access_arbiter_if.master cmd,

  output logic              busy_o,
  output logic              proto_err_o
);

  if (MAX_RD_STREAK < 1) begin : g_bad_streak
    $error("MAX_RD_STREAK must be at least 1");
  end

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              rd_gnt_q, rd_gnt_d;
  logic              wr_gnt_q, wr_gnt_d;
  logic              rd_done_q, rd_done_d;
  logic              wr_done_q, wr_done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              sel_wr;

`ifdef FB_ARB_STARVE_EN
  localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;

  // Writes win a contested IDLE cycle once reads have taken MAX_RD_STREAK grants in a row.
  always_comb begin
    sel_wr   = wr_req_i && (!rd_req_i || (streak_q == STREAK_MAX));
    streak_d = streak_q;
    if ((state_q == IDLE) && (rd_req_i || wr_req_i)) begin
      if (sel_wr) begin
        streak_d = '0;
      end else if (wr_req_i && (streak_q != STREAK_MAX)) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  always_comb begin
    sel_wr = wr_req_i && !rd_req_i;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      owner_q   <= OWN_RD;
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      rd_gnt_q  <= 1'b0;
      wr_gnt_q  <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      valid_q   <= valid_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      rd_gnt_q  <= rd_gnt_d;
      wr_gnt_q  <= wr_gnt_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    len_d     = len_q;
    rd_gnt_d  = 1'b0;
    wr_gnt_d  = 1'b0;
    rd_done_d = 1'b0;
    wr_done_d = 1'b0;
    err_d     = err_q | (cmd.xfer_done_i && (state_q != WAIT));

    unique case (state_q)
      IDLE: begin
        if (rd_req_i || wr_req_i) begin
          state_d = ISSUE;
          owner_d = sel_wr ? OWN_WR : OWN_RD;
          we_d    = sel_wr;
          addr_d  = sel_wr ? wr_addr_i : rd_addr_i;
          len_d   = sel_wr ? wr_len_i  : rd_len_i;
        end
      end
      ISSUE: begin
        if (cmd.cmd_ready_i) begin
          state_d  = WAIT;
          rd_gnt_d = (owner_q == OWN_RD);
          wr_gnt_d = (owner_q == OWN_WR);
        end
      end
      WAIT: begin
        if (cmd.xfer_done_i) begin
          state_d   = IDLE;
          rd_done_d = (owner_q == OWN_RD);
          wr_done_d = (owner_q == OWN_WR);
        end
      end
      default: state_d = IDLE;
    endcase

    // Valid and busy are registered copies of the next state so outputs stay flop-driven.
    valid_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);
  end

  assign cmd.cmd_valid_o = valid_q;
  assign cmd.cmd_we_o    = we_q;
  assign cmd.cmd_addr_o  = addr_q;
  assign cmd.cmd_len_o   = len_q;
  assign rd_gnt_o        = rd_gnt_q;
  assign wr_gnt_o        = wr_gnt_q;
  assign rd_done_o       = rd_done_q;
  assign wr_done_o       = wr_done_q;
  assign busy_o          = busy_q;
  assign proto_err_o     = err_q;

endmodule
